sumador_serie_64: RTL and testbench

Sequential 64-bit adder front-end that time-multiplexes the team's existing 16-bit carry-select adder (`CSA16bits`). It latches two wide operands and a carry-in. It then feeds the adder one 16-bit word per clock, least-significant word first, chaining the carry through a register. It captures each partial sum and reports the full result with a one-cycle `done` pulse. It sits directly upstream and downstream of `CSA16bits`: it drives that block's A/B/Cin and consumes its S/Cout.

---
 rtl/sumador_serie_64.sv | 131 +++++++++++++
 tb/tb_sumador_serie_64.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/sumador_serie_64.sv
// sumador_serie_64
//   Sequential wide adder front-end. Latches two operands and a carry-in,
//   then streams them one 16-bit word per clock (LS word first) through an
//   external CSA16bits adder, chaining the carry through a register and
//   collecting each partial sum into S. A one-cycle done pulse marks the
//   complete result.
//
// Ports
//   clk, rst_n     : clock (rising edge), asynchronous active-low reset
//   start          : request an addition, honoured only when idle
//   A, B, Cin      : operands and carry-in, latched when start is accepted
//   busy           : high while words are being streamed
//   done           : one-cycle pulse when S/Cout hold the full result
//   S, Cout        : registered sum and carry out of the top word
//   add_a, add_b   : current operand words toward CSA16bits.A / .B
//   add_cin        : chained carry toward CSA16bits.Cin
//   add_s, add_cout: CSA16bits.S / .Cout returned for capture
module sumador_serie_64 #(
  parameter int unsigned WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [16*WORDS-1:0]   A,
  input  logic [16*WORDS-1:0]   B,
  input  logic                  Cin,
  output logic                  busy,
  output logic                  done,
  output logic [16*WORDS-1:0]   S,
  output logic                  Cout,
  output logic [15:0]           add_a,
  output logic [15:0]           add_b,
  output logic                  add_cin,
  input  logic [15:0]           add_s,
  input  logic                  add_cout
);

  localparam int unsigned W  = 16 * WORDS;
  localparam int unsigned IW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_next;

  logic [IW-1:0]   r_idx;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [W-1:0]    r_s;
  logic            r_carry;
  logic            r_cout;
  logic            r_done;

  logic            w_accept;
  logic            w_last;
  logic [IW+3:0]   w_base;   // bit offset of the current word (idx*16)

  assign w_accept = (r_state == ST_IDLE) && start;
  assign w_last   = (r_state == ST_RUN) && (r_idx == IW'(WORDS - 1));
  assign w_base   = {r_idx, 4'b0000};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (start)  w_next = ST_RUN;
      ST_RUN:  if (w_last) w_next = ST_IDLE;
      default:             w_next = ST_IDLE;
    endcase
  end

  // Datapath: operand latch, per-word capture and carry chaining
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_s     <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_a     <= A;
        r_b     <= B;
        r_carry <= Cin;
        r_idx   <= '0;
      end else if (r_state == ST_RUN) begin
        r_s[w_base +: 16] <= add_s;
        r_carry           <= add_cout;
        r_idx             <= r_idx + 1'b1;
        if (w_last) begin
          r_cout <= add_cout;
          r_done <= 1'b1;
        end
      end
    end
  end

  // Adder-facing outputs are decoded purely from registers and forced
  // to zero outside RUN so the external adder sees quiet inputs.
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (r_state == ST_RUN) begin
      add_a   = r_a[w_base +: 16];
      add_b   = r_b[w_base +: 16];
      add_cin = r_carry;
    end
  end

  assign busy = (r_state == ST_RUN);
  assign done = r_done;
  assign S    = r_s;
  assign Cout = r_cout;

endmodule

// File: tb/tb_sumador_serie_64.sv
module tb_sumador_serie_64;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [63:0] A;
  logic [63:0] B;
  logic        Cin;
  logic        busy;
  logic        done;
  logic [63:0] S;
  logic        Cout;
  logic [15:0] add_a;
  logic [15:0] add_b;
  logic        add_cin;
  logic [15:0] add_s;
  logic        add_cout;

  int unsigned errors = 0;
  int unsigned checks = 0;

  logic [64:0] sb[$];

  sumador_serie_64 #(.WORDS(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .A        (A),
    .B        (B),
    .Cin      (Cin),
    .busy     (busy),
    .done     (done),
    .S        (S),
    .Cout     (Cout),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_cin  (add_cin),
    .add_s    (add_s),
    .add_cout (add_cout)
  );

  // Behavioural stand-in for the external 16-bit adder
  always_comb begin
    {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {16'd0, add_cin};
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [64:0] ref_sum(input logic [63:0] a, input logic [63:0] b,
                                          input logic c);
    ref_sum = {1'b0, a} + {1'b0, b} + {64'd0, c};
  endfunction

  task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 with no pending op, expected none");
      end else begin
        chk("result", {Cout, S}, sb.pop_front());
      end
    end
  end

  // One isolated operation with cycle-accurate busy/done checks.
  // With ign_start, start is pulsed during RUN with other operands.
  task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic c,
                        input bit chk_cin1, input bit ign_start);
    @(negedge clk);
    A = a; B = b; Cin = c; start = 1'b1;
    sb.push_back(ref_sum(a, b, c));
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (ign_start && k < 3) begin
        start = 1'b1;
        A = {$urandom, $urandom};
        B = {$urandom, $urandom};
        Cin = 1'($urandom);
      end else begin
        start = 1'b0;
      end
      chk("busy_run", {64'd0, busy}, 65'd1);
      chk("done_run", {64'd0, done}, 65'd0);
      if (chk_cin1) chk("add_cin_chain", {64'd0, add_cin}, 65'd1);
    end
    @(negedge clk);
    chk("done_pulse", {64'd0, done}, 65'd1);
    chk("busy_done", {64'd0, busy}, 65'd0);
    @(negedge clk);
    chk("done_width", {64'd0, done}, 65'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    logic [63:0] na, nb;
    logic        nc;

    rst_n = 1'b0; start = 1'b0; A = '0; B = '0; Cin = 1'b0;
    #1;
    chk("rst_busy", {64'd0, busy}, 65'd0);
    chk("rst_done", {64'd0, done}, 65'd0);
    chk("rst_sum", {Cout, S}, 65'd0);
    chk("rst_add", {32'd0, add_a, add_b, add_cin}, 65'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Full carry ripple through every word
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b1, 1'b0);
    // Mixed words: expect S=BCDF_0001_0001_0000, Cout=0
    run_op(64'hABCD_1234_8000_FFFF, 64'h1111_EDCC_8000_0001, 1'b0, 1'b0, 1'b0);
    // Top-word overflow: expect S=0, Cout=1
    run_op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 1'b0);
    // start pulses during RUN must be ignored
    run_op(64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b1, 1'b0, 1'b1);

    // Reset in the middle of RUN (after edge E2)
    @(negedge clk);
    A = '1; B = '1; Cin = 1'b1; start = 1'b1;
    @(posedge clk);            // E0
    @(negedge clk); start = 1'b0;
    @(posedge clk);            // E1
    @(posedge clk);            // E2
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_busy", {64'd0, busy}, 65'd0);
    chk("midrst_done", {64'd0, done}, 65'd0);
    chk("midrst_sum", {Cout, S}, 65'd0);
    chk("midrst_add", {32'd0, add_a, add_b, add_cin}, 65'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);   // a stray done here is flagged by the monitor
    chk("midrst_idle", {63'd0, busy, done}, 65'd0);
    run_op(64'h0000_0000_FFFF_FFFF, 64'h0000_0000_0000_0001, 1'b0, 1'b0, 1'b0);

    // Back-to-back: start held high, new operands presented in each done cycle
    @(negedge clk);
    A = 64'hFFFF_0000_FFFF_0000; B = 64'h0001_0000_0001_0000; Cin = 1'b0;
    start = 1'b1;
    sb.push_back(ref_sum(A, B, Cin));
    for (int i = 0; i < 1000; i++) begin
      repeat (5) @(posedge clk);
      @(negedge clk);
      chk("b2b_done", {64'd0, done}, 65'd1);
      na = {$urandom, $urandom};
      nb = {$urandom, $urandom};
      nc = 1'($urandom);
      if (i == 999) begin
        start = 1'b0;
      end else begin
        A = na; B = nb; Cin = nc;
        sb.push_back(ref_sum(na, nb, nc));
      end
    end
    repeat (8) @(negedge clk);
    chk("pending_ops", {33'd0, 32'(sb.size())}, 65'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
